// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl - time-multiplexed scan controller for N_DIGITS common-anode
// digits sharing one BCD-to-7-segment decoder.
//
// Every digit slot is REFRESH_DIV cycles long. The first BLANK_CYCLES cycles
// of a slot have all anodes off, which stops the previous digit ghosting.
// A new frame is loaded into a shadow register through a load/ready
// handshake. It is copied into the display register on the frame_end cycle,
// so the display never shows part of one frame and part of another.
//
// Optional build macro: DISP_SCAN_LZ_BLANK_EN enables leading-zero suppression.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_load       request to accept i_value_in
//   i_value_in   BCD frame, digit k in bits [4k+3:4k], digit 0 rightmost
//   o_ready      controller accepts a load this cycle
//   o_w          BCD code to the decoder
//   o_an         digit enables, active-low
//   o_bcd_err    sticky: last accepted frame contained a digit > 9
//   o_frame_end  one-cycle pulse on the last cycle of digit N_DIGITS-1
module disp_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_value_in,
  output logic                  o_ready,
  output logic [3:0]            o_w,
  output logic [N_DIGITS-1:0]   o_an,
  output logic                  o_bcd_err,
  output logic                  o_frame_end
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(N_DIGITS - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_disp;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic                  r_pending;
  logic                  r_ready;
  logic                  r_bcd_err;
  logic [N_DIGITS-1:0]   r_an;
  logic [3:0]            r_w;
  logic                  r_frame_end;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_slot_end;
  logic                  w_commit;
  logic                  w_accept;
  logic                  w_frame_err;
  logic [4*N_DIGITS-1:0] w_disp_nxt;
  logic [3:0]            w_digit;
  logic                  w_digit_ok;
  logic                  w_lz;
  logic [N_DIGITS-1:0]   w_an_nxt;
  logic [3:0]            w_w_nxt;
  logic                  w_frame_end_nxt;

`ifdef DISP_SCAN_LZ_BLANK_EN
  // Mask of an all-zero frame: everything except digit 0 suppressed.
  localparam logic [N_DIGITS-1:0] MASK_ZERO = {{(N_DIGITS-1){1'b1}}, 1'b0};
  logic [N_DIGITS-1:0] r_mask;
  logic [N_DIGITS-1:0] w_mask_cmt;
  logic [N_DIGITS-1:0] w_mask_nxt;
  logic                w_allz;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_slot_end  = (r_cnt == CNT_LAST);
    w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;

    case (r_state)
      S_BLANK: if (r_cnt == CNT_BLANK_END) w_state_nxt = S_DRIVE;
      S_DRIVE: if (w_slot_end) begin
        w_state_nxt = S_BLANK;
        w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      default: w_state_nxt = S_BLANK;
    endcase

    // r_frame_end is high exactly on the frame boundary cycle.
    w_commit = r_frame_end && r_pending;
    w_accept = i_load && r_ready;

    w_frame_err = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (i_value_in[4*k +: 4] > 4'd9) w_frame_err = 1'b1;
    end

    w_disp_nxt = w_commit ? r_shadow : r_disp;

`ifdef DISP_SCAN_LZ_BLANK_EN
    w_mask_cmt = '0;
    w_allz     = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_allz        = w_allz && (r_shadow[4*k +: 4] == 4'd0);
      w_mask_cmt[k] = w_allz;
    end
    w_mask_nxt = w_commit ? w_mask_cmt : r_mask;
    w_lz       = w_mask_nxt[w_idx_nxt];
`else
    w_lz = 1'b0;
`endif

    // Outputs are registered from next-state values so they line up with
    // the state they describe, with no extra cycle of lag.
    w_digit    = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_digit_ok = (w_digit <= 4'd9);
    w_an_nxt   = '1;
    if (w_state_nxt == S_DRIVE && w_digit_ok && !w_lz) w_an_nxt[w_idx_nxt] = 1'b0;
    w_w_nxt         = w_digit_ok ? w_digit : 4'd0;
    w_frame_end_nxt = (w_state_nxt == S_DRIVE) && (w_cnt_nxt == CNT_LAST) &&
                      (w_idx_nxt == IDX_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_disp      <= '0;
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      r_ready     <= 1'b1;
      r_bcd_err   <= 1'b0;
      r_an        <= '1;
      r_w         <= 4'd0;
      r_frame_end <= 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
      r_mask      <= MASK_ZERO;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_disp      <= w_disp_nxt;
      r_an        <= w_an_nxt;
      r_w         <= w_w_nxt;
      r_frame_end <= w_frame_end_nxt;
`ifdef DISP_SCAN_LZ_BLANK_EN
      r_mask      <= w_mask_nxt;
`endif
      // Accept and commit are exclusive: a pending frame holds ready low.
      if (w_commit) begin
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end else if (w_accept) begin
        r_shadow  <= i_value_in;
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
        r_bcd_err <= w_frame_err;
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_w         = r_w;
  assign o_an        = r_an;
  assign o_bcd_err   = r_bcd_err;
  assign o_frame_end = r_frame_end;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;
  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = ND * RD;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value_in;
  logic        ready;
  logic [3:0]  w;
  logic [3:0]  an;
  logic        bcd_err;
  logic        frame_end;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scan position is derived from the cycle count since reset.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic        m_ready;
  logic        m_err;

  disp_scan_ctrl #(.N_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_value_in  (value_in),
    .o_ready     (ready),
    .o_w         (w),
    .o_an        (an),
    .o_bcd_err   (bcd_err),
    .o_frame_end (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, m_t, obs, exp);
    end
  endtask

  function automatic logic has_bad(input logic [15:0] f);
    logic bad = 1'b0;
    for (int k = 0; k < ND; k++)
      if (((f >> (4 * k)) & 16'hF) > 16'd9) bad = 1'b1;
    return bad;
  endfunction

  task automatic model_reset();
    m_t = 0; m_disp = '0; m_shadow = '0;
    m_pending = 1'b0; m_ready = 1'b1; m_err = 1'b0;
  endtask

  task automatic compare_all();
    int          pos, idx;
    logic [3:0]  d;
    logic        lz;
    logic [3:0]  one_hot;
    logic [3:0]  exp_an;
    pos = m_t % RD;
    idx = (m_t / RD) % ND;
    d   = 4'((m_disp >> (4 * idx)) & 16'hF);
    lz  = 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
    lz = (idx > 0) && ((m_disp >> (4 * idx)) == 16'd0);
`endif
    one_hot = 4'b0001 << idx;
    exp_an  = (pos >= BL && d <= 4'd9 && !lz) ? ~one_hot : 4'b1111;
    check("an", 32'(an), 32'(exp_an));
    check("w", 32'(w), 32'((d <= 4'd9) ? d : 4'd0));
    check("ready", 32'(ready), 32'(m_ready));
    check("bcd_err", 32'(bcd_err), 32'(m_err));
    check("frame_end", 32'(frame_end), 32'((m_t % FRAME) == FRAME - 1));
  endtask

  task automatic cyc(input logic ld, input logic [15:0] val, input logic r);
    logic commit, accept;
    load = ld; value_in = val; rst = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      commit = ((m_t % FRAME) == FRAME - 1) && m_pending;
      accept = ld && m_ready;
      if (commit) begin
        m_disp = m_shadow; m_pending = 1'b0; m_ready = 1'b1;
      end
      if (accept) begin
        m_shadow = val; m_pending = 1'b1; m_ready = 1'b0; m_err = has_bad(val);
      end
      m_t++;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!m_ready && k < 100) begin
      cyc(1'b0, 16'h0, 1'b0);
      k++;
    end
    check("wait_ready_timeout", 32'(m_ready), 32'd1);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while ((m_t % FRAME) != ph && k < 2 * FRAME) begin
      cyc(1'b0, 16'h0, 1'b0);
      k++;
    end
    check("wait_phase_timeout", 32'(m_t % FRAME), 32'(ph));
  endtask

  function automatic logic [15:0] rand_frame();
    logic [15:0] f = '0;
    int r;
    for (int k = 0; k < ND; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)      f = f | (16'(r % 10) << (4 * k));
      else if (r < 18) f = f;
      else             f = f | (16'($urandom_range(10, 15)) << (4 * k));
    end
    return f;
  endfunction

  initial begin
    model_reset();
    rst = 1'b1; load = 1'b0; value_in = '0;
    repeat (3) cyc(1'b0, 16'h0, 1'b1);

    // Scan order
    cyc(1'b0, 16'h0, 1'b0);
    cyc(1'b1, 16'h1234, 1'b0);
    idle(100);

    // Handshake: second load while not ready is ignored
    wait_ready();
    cyc(1'b1, 16'h5678, 1'b0);
    cyc(1'b1, 16'h9999, 1'b0);
    idle(80);

    // Invalid digit, then clearing frame
    wait_ready();
    cyc(1'b1, 16'h12A4, 1'b0);
    idle(70);
    wait_ready();
    cyc(1'b1, 16'h0007, 1'b0);
    idle(40);

    // Reset during digit 2 drive phase with a frame pending
    wait_ready();
    wait_phase(0);
    cyc(1'b1, 16'h4321, 1'b0);
    wait_phase(2 * RD + 4);
    check("pending_before_rst", 32'(m_pending), 32'd1);
    cyc(1'b0, 16'h0, 1'b1);
    idle(80);

    // Leading zeros
    wait_ready();
    cyc(1'b1, 16'h0050, 1'b0);
    idle(70);
    wait_ready();
    cyc(1'b1, 16'h0000, 1'b0);
    idle(70);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0)
        cyc(1'b0, 16'h0, 1'b1);
      else
        cyc(($urandom_range(0, 7) == 0), rand_frame(), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one disp_dec BCD-to-7-segment decoder among N_DIGITS common-anode digits.
- Holds a double-buffered BCD frame and steps through the digits at a fixed refresh rate.
- Drives the decoder input `w` and the digit-enable lines `an`, with a blanking guard between digits against ghosting.
- Sits between the counter/arithmetic logic that produces BCD values and the board's display pins.

Parameters:
- N_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, blank plus drive; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- load  in  1  request to accept value_in
- value_in  in  4*N_DIGITS  BCD frame; digit k occupies bits [4k+3:4k]; digit 0 is rightmost
- ready  out  1  controller can accept a load this cycle
- w  out  4  BCD code to disp_dec input
- an  out  N_DIGITS  digit enables, active-low, one-hot-low when driving
- bcd_err  out  1  sticky flag: an accepted frame contained a digit > 9
- frame_end  out  1  one-cycle pulse on the last cycle of digit N_DIGITS-1

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - an = all ones; w = 4'b0000; ready = 1; bcd_err = 0; frame_end = 0.
  - Display and shadow registers = 0; digit index = 0; slot counter = 0; FSM = S_BLANK.
- rst asserted mid-scan or mid-handshake: next cycle matches the reset values; any pending frame is discarded.
- Handshake:
  - A load is accepted when load && ready at a rising edge; value_in is captured into the shadow register.
  - ready drops the following cycle and stays low while an update is pending.
  - load while ready = 0 is ignored; no capture, no error.
- Frame commit:
  - A pending shadow frame is copied into the display register on the cycle frame_end is asserted.
  - The new frame starts at digit 0 of the next slot, so there is no mid-frame tearing.
  - ready returns to 1 on the cycle after the commit.
  - A load accepted on the same cycle as a commit opportunity waits for the next frame boundary.
- Slot counter: width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1, then wraps to 0 and the digit index advances.
- Digit index: wraps from N_DIGITS-1 to 0.
- FSM:
  - S_BLANK: an = all ones; w = current digit's code. Moves to S_DRIVE when the counter reaches BLANK_CYCLES-1.
  - S_DRIVE: an[idx] = 0, all other bits 1; w = display digit idx. At counter REFRESH_DIV-1, goes to S_BLANK with idx+1.
- frame_end: high exactly on the S_DRIVE cycle where counter = REFRESH_DIV-1 and idx = N_DIGITS-1.
- Invalid digit (code > 9) in the display register:
  - Its slot stays blanked (an all ones for the whole slot) and w = 4'b0000.
  - bcd_err is set when the offending frame is accepted; it is cleared only when a later accepted frame is all-valid, or by rst.
- Latency: first lit digit appears BLANK_CYCLES cycles after reset release. A new value is visible at most one full frame plus BLANK_CYCLES after acceptance.

Optional Feature:
- Macro: DISP_SCAN_LZ_BLANK_EN.
- When defined: leading zeros are suppressed. Any digit k that is 0 and has all higher digits (k+1..N_DIGITS-1) also 0 is blanked for its whole slot. Digit 0 is never suppressed, so a frame of all zeros still shows one "0". Suppression is computed at commit time and stored as a per-digit mask register.
- When undefined: all valid digits are driven, including leading zeros. No mask register exists.

Test Plan:
- Bench parameters for all tests: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: hold rst for 3 cycles -> an = 4'b1111, w = 0, ready = 1, bcd_err = 0.
- Scan order:
  - Stimulus: load 16'h1234 at cycle 1 after reset.
  - Response: after commit, an cycles 1110/1101/1011/0111 with w = 4, 3, 2, 1. Each slot is 2 cycles at an = 1111, then 6 driven cycles. frame_end pulses once every 32 cycles.
- Handshake:
  - Stimulus: load 16'h5678, then load 16'h9999 while ready = 0.
  - Response: the second load is ignored; the display shows 5678 after the frame boundary; ready rises the cycle after the commit.
- Invalid digit:
  - Stimulus: load 16'h12A4.
  - Response: bcd_err = 1; digit 1 slot keeps an = 1111 for all 8 cycles; the other digits display normally. A subsequent load of 16'h0007 clears bcd_err.
- Reset mid-operation:
  - Stimulus: assert rst during digit 2's drive phase with a load pending.
  - Response: next cycle an = 1111, ready = 1, display register = 0; the pending frame is never shown.
- Leading-zero blanking (DISP_SCAN_LZ_BLANK_EN defined):
  - Stimulus: load 16'h0050.
  - Response: digits 3 and 2 remain blanked; digit 1 shows 5 and digit 0 shows 0.
  - Follow-up: load 16'h0000 -> only digit 0 is lit, showing 0.
